// File: rtl/vmem_arbiter.sv
// Video memory arbiter: display/coprocessor share the read port, CPU/coprocessor share the write port,
// and front/back buffer selection swaps only at a frame boundary.
module vmem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int IMG_AW = 16,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  // display scan-out
  input  logic              disp_req,
  input  logic [IMG_AW-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  // coprocessor read
  input  logic              cp_rd_valid,
  output logic              cp_rd_ready,
  input  logic [ADDR_W-1:0] cp_rd_addr,
  output logic              cp_rvalid,
  output logic [DATA_W-1:0] cp_rdata,
  // CPU write
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  // coprocessor write
  input  logic              cp_wr_valid,
  output logic              cp_wr_ready,
  input  logic [ADDR_W-1:0] cp_waddr,
  input  logic [DATA_W-1:0] cp_wdata,
  // buffer swap
  input  logic              swap_req,
  input  logic              vsync,
  output logic              front_sel,
  output logic              swap_pending,
  // memory side
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a request transfers in any cycle where valid and ready are both high; ready is
  // combinational and never depends on the requester's own data. Read returns have no back-pressure.

  // ---------------------------------------------------------------- read port
  logic rd_fire;
  logic rd_vld_q;
  logic rd_src_disp_q;

  assign cp_rd_ready = ~disp_req;
  assign rd_fire     = disp_req | (cp_rd_valid & cp_rd_ready);
  assign mem_raddr   = disp_req ? {front_sel, disp_addr} : cp_rd_addr;

  // One flag per fired read steers the single returning word to its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q      <= 1'b0;
      rd_src_disp_q <= 1'b0;
    end else begin
      rd_vld_q      <= rd_fire;
      rd_src_disp_q <= disp_req;
    end
  end

  assign disp_rvalid = rd_vld_q & rd_src_disp_q;
  assign cp_rvalid   = rd_vld_q & ~rd_src_disp_q;
  assign disp_rdata  = mem_rdata;
  assign cp_rdata    = mem_rdata;

  // ---------------------------------------------------------------- write port
  logic wr_conflict;
  logic grant_cpu;
  logic grant_cp;
  logic rr_cp_first;   // 1: coprocessor wins the next conflict

  assign wr_conflict = cpu_wr_valid & cp_wr_valid;

  always_comb begin
    grant_cpu = 1'b0;
    grant_cp  = 1'b0;
    if (wr_conflict) begin
      grant_cpu = ~rr_cp_first;
      grant_cp  = rr_cp_first;
    end else begin
      grant_cpu = cpu_wr_valid;
      grant_cp  = cp_wr_valid;
    end
  end

  // The pointer only moves when both sides actually competed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_cp_first <= 1'b0;
    end else if (wr_conflict) begin
      rr_cp_first <= grant_cpu;
    end
  end

  assign cpu_wr_ready = grant_cpu;
  assign cp_wr_ready  = grant_cp;
  assign mem_we       = grant_cpu | grant_cp;
  assign mem_waddr    = grant_cp ? cp_waddr : cpu_waddr;
  assign mem_wdata    = grant_cp ? cp_wdata : cpu_wdata;

  // ---------------------------------------------------------------- buffer swap
  // A swap_req arriving together with the consuming vsync re-arms pending for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (vsync && swap_pending) begin
      front_sel    <= ~front_sel;
      swap_pending <= swap_req;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

endmodule
